// File: rtl/uart_rx_packet_ctrl_if.sv
// Byte-stream, packet-buffer read port and error-pulse bundle between the
// UART receiver side, the packet controller and the packet consumer.
interface uart_rx_packet_ctrl_if #(
  parameter int ADDR_W = 4
);
  logic [7:0]      rx_data;
  logic            rx_ready;
  logic            pkt_valid;
  logic [ADDR_W:0] pkt_len;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]      rd_data;
  logic            pkt_ack;
  logic            err_len;
  logic            err_chk;
  logic            err_timeout;
  logic            err_overrun;

  modport master (
    output rx_data, rx_ready, rd_addr, pkt_ack,
    input  pkt_valid, pkt_len, rd_data, err_len, err_chk, err_timeout, err_overrun
  );

  modport slave (
    input  rx_data, rx_ready, rd_addr, pkt_ack,
    output pkt_valid, pkt_len, rd_data, err_len, err_chk, err_timeout, err_overrun
  );
endinterface

// File: rtl/uart_rx_packet_ctrl.sv
// Frames the UART byte stream into SOF/LEN/payload/checksum packets, buffers
// one good packet for the consumer and reports length, checksum, timeout and overrun errors.
module uart_rx_packet_ctrl #(
  parameter logic [7:0] SOF_BYTE       = 8'hA5,
  parameter int         MAX_PAYLOAD    = 16,
  parameter int         ADDR_W         = 4,
  parameter int         TIMEOUT_CYCLES = 1000
) (
  input logic                clk,
  input logic                reset,
  uart_rx_packet_ctrl_if.slave bus
);
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CHECK, HOLD} state_t;

  state_t            state_reg, state_next;
  logic              ready_q_reg;
  logic [ADDR_W:0]   len_reg, len_next;
  logic [ADDR_W:0]   pkt_len_reg, pkt_len_next;
  logic [ADDR_W-1:0] idx_reg, idx_next;
  logic [7:0]        sum_reg, sum_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              err_len_reg, err_len_next;
  logic              err_chk_reg, err_chk_next;
  logic              err_timeout_reg, err_timeout_next;
  logic              err_overrun_reg, err_overrun_next;
  logic [7:0]        rd_data_reg;
  logic [7:0]        buf_mem [MAX_PAYLOAD];

  logic       accept;
  logic       in_frame;
  logic       wr_en;
  logic [7:0] sum_plus_byte;

  assign accept        = bus.rx_ready & ~ready_q_reg;
  assign in_frame      = (state_reg == LEN) || (state_reg == PAYLOAD) || (state_reg == CHECK);
  assign sum_plus_byte = sum_reg + bus.rx_data;

  always_comb begin
    state_next       = state_reg;
    len_next         = len_reg;
    pkt_len_next     = pkt_len_reg;
    idx_next         = idx_reg;
    sum_next         = sum_reg;
    cnt_next         = cnt_reg;
    err_len_next     = 1'b0;
    err_chk_next     = 1'b0;
    err_timeout_next = 1'b0;
    err_overrun_next = 1'b0;
    wr_en            = 1'b0;

    // An accepted byte always restarts the gap timer, so it beats a same-cycle expiry.
    if (accept) begin
      cnt_next = '0;
    end else if (in_frame) begin
      if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        err_timeout_next = 1'b1;
        state_next       = IDLE;
        cnt_next         = '0;
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end

    case (state_reg)
      IDLE: begin
        if (accept && bus.rx_data == SOF_BYTE) state_next = LEN;
      end
      LEN: begin
        if (accept) begin
          if (int'(bus.rx_data) > MAX_PAYLOAD) begin
            err_len_next = 1'b1;
            state_next   = IDLE;
          end else begin
            len_next   = (ADDR_W+1)'(bus.rx_data);
            sum_next   = bus.rx_data;
            idx_next   = '0;
            state_next = (bus.rx_data == 8'd0) ? CHECK : PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (accept) begin
          wr_en    = 1'b1;
          sum_next = sum_plus_byte;
          idx_next = idx_reg + ADDR_W'(1);
          if (({1'b0, idx_reg} + (ADDR_W+1)'(1)) == len_reg) state_next = CHECK;
        end
      end
      CHECK: begin
        if (accept) begin
          if (sum_plus_byte == 8'd0) begin
            state_next   = HOLD;
            pkt_len_next = len_reg;
          end else begin
            err_chk_next = 1'b1;
            state_next   = IDLE;
          end
        end
      end
      HOLD: begin
        // A byte arriving with the ack is still an overrun; it is never taken as SOF.
        if (accept) err_overrun_next = 1'b1;
        if (bus.pkt_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      ready_q_reg     <= 1'b0;
      len_reg         <= '0;
      pkt_len_reg     <= '0;
      idx_reg         <= '0;
      sum_reg         <= '0;
      cnt_reg         <= '0;
      err_len_reg     <= 1'b0;
      err_chk_reg     <= 1'b0;
      err_timeout_reg <= 1'b0;
      err_overrun_reg <= 1'b0;
      rd_data_reg     <= '0;
    end else begin
      state_reg       <= state_next;
      ready_q_reg     <= bus.rx_ready;
      len_reg         <= len_next;
      pkt_len_reg     <= pkt_len_next;
      idx_reg         <= idx_next;
      sum_reg         <= sum_next;
      cnt_reg         <= cnt_next;
      err_len_reg     <= err_len_next;
      err_chk_reg     <= err_chk_next;
      err_timeout_reg <= err_timeout_next;
      err_overrun_reg <= err_overrun_next;
      rd_data_reg     <= buf_mem[bus.rd_addr];
    end
  end

  // Payload storage kept free of reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) buf_mem[idx_reg] <= bus.rx_data;
  end

  assign bus.pkt_valid   = (state_reg == HOLD);
  assign bus.pkt_len     = pkt_len_reg;
  assign bus.rd_data     = rd_data_reg;
  assign bus.err_len     = err_len_reg;
  assign bus.err_chk     = err_chk_reg;
  assign bus.err_timeout = err_timeout_reg;
  assign bus.err_overrun = err_overrun_reg;
endmodule

// File: tb/tb_uart_rx_packet_ctrl.sv
// Directed bench for uart_rx_packet_ctrl: expected packets are queued as frames
// are sent and popped when the controller presents a held packet.
module tb_uart_rx_packet_ctrl;
  localparam int ADDR_W         = 4;
  localparam int MAX_PAYLOAD    = 16;
  localparam int TIMEOUT_CYCLES = 1000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_rx_packet_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  uart_rx_packet_ctrl #(
    .SOF_BYTE(8'hA5),
    .MAX_PAYLOAD(MAX_PAYLOAD),
    .ADDR_W(ADDR_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int n_len = 0, n_chk = 0, n_to = 0, n_ovr = 0, n_wide = 0;

  int         exp_len_q[$];
  logic [7:0] exp_byte_q[$];
  logic [7:0] frame_pl[$];

  wire [3:0] err_vec = {bus.err_len, bus.err_chk, bus.err_timeout, bus.err_overrun};
  logic [3:0] err_prev = 4'b0;

  // Pulse counters; a flag seen high on two consecutive edges counts as a wide pulse.
  always @(posedge clk) begin
    if (bus.err_len)     n_len <= n_len + 1;
    if (bus.err_chk)     n_chk <= n_chk + 1;
    if (bus.err_timeout) n_to  <= n_to + 1;
    if (bus.err_overrun) n_ovr <= n_ovr + 1;
    if ((err_vec & err_prev) != 4'b0) n_wide <= n_wide + 1;
    err_prev <= err_vec;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-28s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
    tick();
  endtask

  // Sends SOF, LEN, frame_pl and the two's-complement checksum of LEN+payload.
  task automatic send_frame(input bit push);
    logic [7:0] s;
    s = 8'(frame_pl.size());
    if (push) begin
      exp_len_q.push_back(frame_pl.size());
      foreach (frame_pl[i]) exp_byte_q.push_back(frame_pl[i]);
    end
    send_byte(8'hA5);
    send_byte(8'(frame_pl.size()));
    foreach (frame_pl[i]) begin
      send_byte(frame_pl[i]);
      s = s + frame_pl[i];
    end
    send_byte(8'h00 - s);
  endtask

  task automatic expect_packet(input string tag);
    int n;
    int l;
    n = 0;
    while (!bus.pkt_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, " pkt_valid"}, 32'(bus.pkt_valid), 32'd1);
    chk({tag, " scoreboard"}, 32'(exp_len_q.size() != 0), 32'd1);
    if (exp_len_q.size() != 0) begin
      l = exp_len_q.pop_front();
      chk({tag, " pkt_len"}, 32'(bus.pkt_len), 32'(l));
      for (int i = 0; i < l; i++) begin
        bus.rd_addr = ADDR_W'(i);
        tick();
        chk($sformatf("%s rd_data[%0d]", tag, i), 32'(bus.rd_data), 32'(exp_byte_q.pop_front()));
      end
    end
    bus.pkt_ack = 1'b1;
    tick();
    bus.pkt_ack = 1'b0;
    chk({tag, " released"}, 32'(bus.pkt_valid), 32'd0);
  endtask

  initial begin
    int c0, c1, c2, c3, n;
    bus.rx_data  = 8'h00;
    bus.rx_ready = 1'b0;
    bus.rd_addr  = '0;
    bus.pkt_ack  = 1'b0;
    reset = 1'b1;
    idle(3);
    chk("reset pkt_valid", 32'(bus.pkt_valid), 32'd0);
    chk("reset pkt_len", 32'(bus.pkt_len), 32'd0);
    chk("reset rd_data", 32'(bus.rd_data), 32'd0);
    chk("reset err flags", 32'(err_vec), 32'd0);
    reset = 1'b0;
    tick();

    // 1: good frame with latency check on the checksum byte.
    exp_len_q.push_back(3);
    exp_byte_q.push_back(8'h11); exp_byte_q.push_back(8'h22); exp_byte_q.push_back(8'h33);
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    bus.rx_data  = 8'h97;  // 03+11+22+33 = 69, complement 97
    bus.rx_ready = 1'b1;
    chk("t1 valid during accept", 32'(bus.pkt_valid), 32'd0);
    tick();
    chk("t1 valid one cycle later", 32'(bus.pkt_valid), 32'd1);
    bus.rx_ready = 1'b0;
    tick();
    expect_packet("t1");
    c0 = n_chk;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'hB7);
    idle(2);
    chk("t1 B7 is a bad checksum", 32'(n_chk - c0), 32'd1);
    chk("t1 B7 no packet", 32'(bus.pkt_valid), 32'd0);

    // 2: bad checksum, then a good frame.
    c0 = n_chk;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'h00);
    idle(3);
    chk("t2 err_chk count", 32'(n_chk - c0), 32'd1);
    chk("t2 no packet", 32'(bus.pkt_valid), 32'd0);
    frame_pl = '{8'h55};
    send_frame(1'b1);
    expect_packet("t2");

    // 3: length limits.
    c0 = n_len;
    send_byte(8'hA5); send_byte(8'h11);
    idle(2);
    chk("t3 err_len count", 32'(n_len - c0), 32'd1);
    frame_pl.delete();
    send_frame(1'b1);
    expect_packet("t3 zero");
    frame_pl.delete();
    for (int i = 0; i < MAX_PAYLOAD; i++) frame_pl.push_back(8'($urandom_range(0, 255)));
    send_frame(1'b1);
    expect_packet("t3 full");

    // 4: inter-byte timeout.
    c0 = n_to;
    c1 = n_len + n_chk + n_ovr;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    n = 0;
    while (!bus.err_timeout && n < TIMEOUT_CYCLES + 50) begin
      tick();
      n++;
    end
    chk("t4 err_timeout seen", 32'(bus.err_timeout), 32'd1);
    chk("t4 timeout latency window", 32'(n >= TIMEOUT_CYCLES - 2 && n <= TIMEOUT_CYCLES), 32'd1);
    tick();
    chk("t4 err_timeout one cycle", 32'(bus.err_timeout), 32'd0);
    send_byte(8'h22); send_byte(8'h33);
    idle(3);
    chk("t4 timeout count", 32'(n_to - c0), 32'd1);
    chk("t4 no other errors", 32'(n_len + n_chk + n_ovr - c1), 32'd0);
    chk("t4 no packet", 32'(bus.pkt_valid), 32'd0);
    frame_pl = '{8'h01, 8'h02, 8'h03};
    send_frame(1'b1);
    expect_packet("t4");

    // 5: overrun while holding, then ack racing a byte edge.
    c0 = n_ovr;
    frame_pl = '{8'hC3, 8'h3C};
    send_frame(1'b1);
    send_byte(8'h77);
    idle(1);
    chk("t5 overrun count", 32'(n_ovr - c0), 32'd1);
    chk("t5 still holding", 32'(bus.pkt_valid), 32'd1);
    expect_packet("t5");
    frame_pl = '{8'h99};
    send_frame(1'b0);
    chk("t5 race holding", 32'(bus.pkt_valid), 32'd1);
    c0 = n_ovr;
    bus.pkt_ack  = 1'b1;
    bus.rx_data  = 8'hA5;
    bus.rx_ready = 1'b1;
    tick();
    bus.pkt_ack  = 1'b0;
    bus.rx_ready = 1'b0;
    tick();
    chk("t5 race released", 32'(bus.pkt_valid), 32'd0);
    chk("t5 race overrun", 32'(n_ovr - c0), 32'd1);
    send_byte(8'h01); send_byte(8'h55); send_byte(8'hAA);
    idle(3);
    chk("t5 A5 not taken as SOF", 32'(bus.pkt_valid), 32'd0);

    // 6: reset mid-payload, noise in IDLE, then a good frame.
    c0 = n_len + n_chk + n_to + n_ovr;
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01);
    reset = 1'b1;
    tick();
    chk("t6 reset pkt_valid", 32'(bus.pkt_valid), 32'd0);
    chk("t6 reset pkt_len", 32'(bus.pkt_len), 32'd0);
    chk("t6 reset rd_data", 32'(bus.rd_data), 32'd0);
    chk("t6 reset err flags", 32'(err_vec), 32'd0);
    reset = 1'b0;
    tick();
    send_byte(8'h00); send_byte(8'hFF);
    idle(3);
    c2 = n_len + n_chk + n_to + n_ovr;
    chk("t6 no pulses", 32'(c2 - c0), 32'd0);
    chk("t6 no packet", 32'(bus.pkt_valid), 32'd0);
    frame_pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_frame(1'b1);
    expect_packet("t6");

    c3 = exp_len_q.size();
    chk("scoreboard drained", 32'(c3), 32'd0);
    chk("error pulses single cycle", 32'(n_wide), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
